// File: rtl/icache_pkg.sv
// icache_pkg: FSM encoding, Wishbone burst codes and default line geometry for the I-cache refill controller
package icache_pkg;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_RETRY_MAX = 4;
  localparam int DEF_RETRY_GAP = 2;
  localparam int DEF_IDX_W = $clog2(DEF_LINE_WORDS);
  localparam int DEF_LINE_W = 32 * DEF_LINE_WORDS;
  localparam logic [2:0] WB_CTI_INCR = 3'b010;
  localparam logic [2:0] WB_CTI_EOB = 3'b111;
  localparam logic [1:0] WB_BTE_LINEAR = 2'b00;
  localparam logic [1:0] WB_BTE_WRAP8 = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_BURST, S_RETRY_WAIT, S_WRITE, S_HOLD} state_t;
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: Wishbone B3 instruction-bus signals between refill master and memory slave
interface icache_refill_ctrl_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_adr_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic [31:0] wb_dat_i;
  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o, wb_cti_o, wb_bte_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
  );
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o, wb_cti_o, wb_bte_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
  );
endinterface

// File: rtl/icache_line_assembler.sv
// icache_line_assembler: line register written one word per ack, cleared by the first ack of each burst attempt
module icache_line_assembler #(
  parameter int LINE_WORDS = 8,
  parameter int IDX_W = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic                     clr,
  input  logic [IDX_W-1:0]         idx,
  input  logic [31:0]              dat,
  output logic [32*LINE_WORDS-1:0] line
);
  logic [32*LINE_WORDS-1:0] line_q, line_d;
  always_comb begin
    line_d = (wr && clr) ? '0 : line_q;
    if (wr) line_d[{idx, 5'd0} +: 32] = dat;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_q <= '0;
    else line_q <= line_d;
  end
  assign line = line_q;
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: Wishbone B3 I-cache line refill sequencer; define ICACHE_REFILL_CWF_EN for critical-word-first
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int RETRY_MAX = DEF_RETRY_MAX,
  parameter int RETRY_GAP = DEF_RETRY_GAP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_req,
  input  logic [31:0]              miss_addr,
  input  logic                     flush,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                     line_we,
  output logic                     refill_busy,
  output logic                     freeze_out,
  output logic                     refill_err,
  output logic                     crit_valid,
  output logic [31:0]              crit_instr,
  icache_refill_ctrl_if.master     wb
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int RTY_W = $clog2(RETRY_MAX + 1);
  localparam int GAP_W = $clog2(RETRY_GAP + 1);
  state_t state_q, state_d;
  logic [31-IDX_W-2:0] base_q, base_d;
  logic [IDX_W-1:0] start_q, start_d, beat_q, beat_d, idx;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic fresh_q, fresh_d, err_q, err_d, ack, last, cyc;
  assign cyc = state_q == S_BURST;
  assign idx = start_q + beat_q;
  assign last = beat_q == IDX_W'(LINE_WORDS - 1);
  assign ack = cyc && wb.wb_ack_i && !wb.wb_err_i && !wb.wb_rty_i;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    start_d = start_q;
    beat_d = beat_q;
    rty_d = rty_q;
    gap_d = gap_q;
    fresh_d = fresh_q;
    err_d = 1'b0;
    if (flush) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE: if (miss_req) begin
          state_d = S_BURST;
          base_d = miss_addr[31:IDX_W+2];
`ifdef ICACHE_REFILL_CWF_EN
          start_d = miss_addr[IDX_W+1:2];
`else
          start_d = '0;
`endif
          beat_d = '0;
          rty_d = '0;
          fresh_d = 1'b1;
        end
        S_BURST: if (wb.wb_err_i) begin
          err_d = 1'b1;
          state_d = S_IDLE;
        end else if (wb.wb_rty_i) begin
          rty_d = rty_q + 1'b1;
          beat_d = '0;
          gap_d = '0;
          fresh_d = 1'b1;
          err_d = rty_q == RTY_W'(RETRY_MAX - 1);
          state_d = err_d ? S_IDLE : S_RETRY_WAIT;
        end else if (wb.wb_ack_i) begin
          beat_d = beat_q + 1'b1;
          fresh_d = 1'b0;
          state_d = last ? S_WRITE : S_BURST;
        end
        S_RETRY_WAIT: begin
          gap_d = gap_q + 1'b1;
          state_d = gap_q == GAP_W'(RETRY_GAP - 1) ? S_BURST : S_RETRY_WAIT;
        end
        S_WRITE: state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q <= '0;
      start_q <= '0;
      beat_q <= '0;
      rty_q <= '0;
      gap_q <= '0;
      fresh_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      start_q <= start_d;
      beat_q <= beat_d;
      rty_q <= rty_d;
      gap_q <= gap_d;
      fresh_q <= fresh_d;
      err_q <= err_d;
    end
  end
  icache_line_assembler #(.LINE_WORDS(LINE_WORDS)) u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .wr(ack),
    .clr(fresh_q),
    .idx(idx),
    .dat(wb.wb_dat_i),
    .line(line_data)
  );
  assign wb.wb_cyc_o = cyc;
  assign wb.wb_stb_o = cyc;
  assign wb.wb_we_o = 1'b0;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_dat_o = '0;
  assign wb.wb_adr_o = {base_q, idx, 2'b00};
  assign wb.wb_cti_o = cyc ? (last ? WB_CTI_EOB : WB_CTI_INCR) : 3'b000;
  assign line_we = state_q == S_WRITE;
  assign refill_busy = state_q != S_IDLE;
  assign freeze_out = miss_req | refill_busy;
  assign refill_err = err_q;
`ifdef ICACHE_REFILL_CWF_EN
  logic [1:0] unused_bits;
  assign unused_bits = miss_addr[1:0];
  assign wb.wb_bte_o = cyc ? WB_BTE_WRAP8 : 2'b00;
  assign crit_valid = ack && fresh_q;
  assign crit_instr = crit_valid ? wb.wb_dat_i : 32'h0;
`else
  logic [IDX_W+1:0] unused_bits;
  assign unused_bits = miss_addr[IDX_W+1:0];
  assign wb.wb_bte_o = WB_BTE_LINEAR;
  assign crit_valid = 1'b0;
  assign crit_instr = 32'h0;
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized refill bench against a transaction-level model of the line fetch
module tb_icache_refill_ctrl;
`ifdef ICACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
  localparam logic [1:0] BTE = 2'b10;
`else
  localparam bit CWF = 1'b0;
  localparam logic [1:0] BTE = 2'b00;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic miss_req = 1'b0;
  logic flush = 1'b0;
  logic [31:0] miss_addr = '0;
  logic [255:0] line_data;
  logic line_we, refill_busy, freeze_out, refill_err, crit_valid;
  logic [31:0] crit_instr;
  logic [255:0] prev_line = '0;
  bit prev_valid = 1'b1;
  int checks = 0;
  int errors = 0;
  icache_refill_ctrl_if wb();
  icache_refill_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .miss_req(miss_req),
    .miss_addr(miss_addr),
    .flush(flush),
    .line_data(line_data),
    .line_we(line_we),
    .refill_busy(refill_busy),
    .freeze_out(freeze_out),
    .refill_err(refill_err),
    .crit_valid(crit_valid),
    .crit_instr(crit_instr),
    .wb(wb.master)
  );
  always #5 clk = ~clk;
  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic checkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic slave_idle();
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;
    wb.wb_rty_i = 1'b0;
    wb.wb_dat_i = '0;
  endtask
  task automatic check_all_zero(input string tag);
    check1({tag, "_cyc"}, wb.wb_cyc_o, 1'b0);
    check1({tag, "_stb"}, wb.wb_stb_o, 1'b0);
    check1({tag, "_busy"}, refill_busy, 1'b0);
    check1({tag, "_we"}, line_we, 1'b0);
    check1({tag, "_err"}, refill_err, 1'b0);
    check1({tag, "_crit"}, crit_valid, 1'b0);
    checkv({tag, "_line"}, line_data, 256'h0);
    checkv({tag, "_cti"}, 256'(wb.wb_cti_o), 256'h0);
    checkv({tag, "_crit_instr"}, 256'(crit_instr), 256'h0);
  endtask
  // phase: 0 burst, 1 retry gap, 2 write, 3 hold, 4 done, 5 error reported, 6 flushed
  task automatic refill(input logic [31:0] addr, input int gap_max, input int rty_beat, input int n_rty,
                        input int err_beat, input int flush_beat, input int rst_beat);
    logic [31:0] words [8];
    logic [255:0] exp_line;
    logic [2:0] idx;
    int start, beat, tries, wait_n, phase, gap, t;
    bit done, lat_chk;
    beat = 0;
    tries = 0;
    phase = 0;
    gap = 0;
    t = 0;
    done = 1'b0;
    lat_chk = gap_max == 0 && n_rty == 0 && err_beat < 0 && flush_beat < 0 && rst_beat < 0;
    for (int k = 0; k < 8; k++) begin
      words[k] = $urandom;
      exp_line[32*k +: 32] = words[k];
    end
    start = CWF ? int'(addr[4:2]) : 0;
    @(negedge clk);
    miss_req = 1'b1;
    miss_addr = addr;
    #1;
    check1("idle_busy", refill_busy, 1'b0);
    check1("freeze_miss", freeze_out, 1'b1);
    wait_n = 1 + int'($urandom_range(gap_max, 0));
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
      check1("busy", refill_busy, phase < 4);
      check1("freeze", freeze_out, miss_req | (phase < 4));
      check1("line_we", line_we, phase == 2);
      check1("refill_err", refill_err, phase == 5);
      check1("cyc", wb.wb_cyc_o, phase == 0);
      check1("stb", wb.wb_stb_o, phase == 0);
      miss_req = 1'b0;
      flush = 1'b0;
      slave_idle();
      if (phase == 0) begin
        idx = 3'(start + beat);
        checkv("adr", 256'(wb.wb_adr_o), 256'({addr[31:5], idx, 2'b00}));
        checkv("cti", 256'(wb.wb_cti_o), 256'(beat == 7 ? 3'b111 : 3'b010));
        checkv("bte", 256'(wb.wb_bte_o), 256'(BTE));
        check1("we_o", wb.wb_we_o, 1'b0);
        checkv("sel", 256'(wb.wb_sel_o), 256'(4'hF));
        if (tries == 0 && beat == 0 && prev_valid) checkv("line_hold", line_data, prev_line);
        if (wait_n > 0) wait_n--;
        else if (beat == err_beat) begin
          wb.wb_err_i = 1'b1;
          wb.wb_ack_i = 1'b1;
          wb.wb_dat_i = words[idx];
          phase = 5;
        end else if (beat == rty_beat && tries < n_rty) begin
          wb.wb_rty_i = 1'b1;
          wb.wb_ack_i = 1'($urandom_range(1, 0));
          wb.wb_dat_i = $urandom;
          tries++;
          beat = 0;
          gap = 2;
          wait_n = 1 + int'($urandom_range(gap_max, 0));
          phase = tries == 4 ? 5 : 1;
        end else if (beat == flush_beat) begin
          flush = 1'b1;
          phase = 6;
        end else if (beat == rst_beat) begin
          #2 rst_n = 1'b0;
          #1 check_all_zero("async_rst");
          @(negedge clk);
          rst_n = 1'b1;
          prev_line = '0;
          prev_valid = 1'b1;
          done = 1'b1;
        end else begin
          wb.wb_ack_i = 1'b1;
          wb.wb_dat_i = words[idx];
          #1;
          check1("crit_valid", crit_valid, CWF && beat == 0);
          checkv("crit_instr", 256'(crit_instr), 256'((CWF && beat == 0) ? words[idx] : 32'h0));
          beat++;
          wait_n = int'($urandom_range(gap_max, 0));
          if (beat == 8) phase = 2;
        end
      end else if (phase == 1) begin
        gap--;
        if (gap == 0) phase = 0;
      end else if (phase == 2) begin
        checkv("line_data", line_data, exp_line);
        if (lat_chk) checkv("latency", 256'(t), 256'(10));
        phase = 3;
      end else if (phase == 3) begin
        checkv("line_stable", line_data, exp_line);
        phase = 4;
      end else begin
        prev_valid = phase == 4;
        if (phase == 4) prev_line = exp_line;
        done = 1'b1;
      end
    end
    check1("timeout", done, 1'b1);
    slave_idle();
    flush = 1'b0;
    miss_req = 1'b0;
  endtask
  initial begin
    slave_idle();
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    check1("reset_freeze", freeze_out, 1'b0);
    checkv("reset_adr", 256'(wb.wb_adr_o), 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    miss_req = 1'b1;
    flush = 1'b1;
    miss_addr = 32'h0000_2000;
    @(negedge clk);
    check1("flush_idle_busy", refill_busy, 1'b0);
    check1("flush_idle_cyc", wb.wb_cyc_o, 1'b0);
    miss_req = 1'b0;
    flush = 1'b0;
    refill(32'h0000_1044, 0, -1, 0, -1, -1, -1);
    refill(32'h0000_1044, 2, -1, 0, -1, -1, -1);
    refill(32'h8000_3ab8, 2, -1, 0, -1, -1, -1);
    refill(32'h0000_1044, 0, 3, 1, -1, -1, -1);
    refill(32'h0000_1044, 1, 3, 4, -1, -1, -1);
    refill(32'h0000_1044, 0, -1, 0, 5, -1, -1);
    refill(32'h0000_1044, 0, -1, 0, -1, 4, -1);
    refill(32'h0000_1044, 1, -1, 0, -1, -1, 4);
    refill(32'h0000_1054, 0, -1, 0, -1, -1, -1);
    for (int r = 0; r < 10; r++)
      refill($urandom, int'($urandom_range(2, 0)), int'($urandom_range(7, 0)), int'($urandom_range(4, 0)),
             (r % 3 == 0) ? int'($urandom_range(7, 0)) : -1, -1, -1);
    refill(32'hdead_beec, 0, -1, 0, -1, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
